operand_fetch_stage: RTL and testbench

Parametrised operand-fetch pipeline stage sitting between instruction fetch and execute. Decodes the opcode, reads two source registers from an internal register file with same-cycle writeback bypass, and tracks pending destination writes in a scoreboard so read-after-write hazards stall the front end. Results leave through a registered valid/ready output bundle. Latency is one cycle at full throughput.

---
 rtl/of_pkg.sv | 36 +++
 rtl/of_decode.sv | 29 ++
 rtl/operand_fetch_stage.sv | 112 +++++++++++
 tb/tb_operand_fetch_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/of_pkg.sv
// Shared constants for the operand-fetch stage: control-word layout,
// instruction field offsets and opcode encodings.
package of_pkg;

  localparam int unsigned CTRL_W        = 8;
  localparam int unsigned OPC_W         = 4;
  localparam int unsigned USE_RD_LSB    = 0;
  localparam int unsigned USE_RD_MSB    = 2;
  localparam int unsigned REG_WRITE_BIT = 3;

  localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h2;
  localparam logic [OPC_W-1:0] OP_AND   = 4'h3;
  localparam logic [OPC_W-1:0] OP_CMP   = 4'h4;
  localparam logic [OPC_W-1:0] OP_INC   = 4'h5;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h6;

  // Instruction fields are packed LSB-first: pc, opcode, rs1, rs2, rd.
  function automatic int unsigned off_opcode(int unsigned pc_w);
    return pc_w;
  endfunction

  function automatic int unsigned off_rs1(int unsigned pc_w);
    return pc_w + OPC_W;
  endfunction

  function automatic int unsigned off_rs2(int unsigned pc_w, int unsigned raw);
    return pc_w + OPC_W + raw;
  endfunction

  function automatic int unsigned off_rd(int unsigned pc_w, int unsigned raw);
    return pc_w + OPC_W + 2 * raw;
  endfunction

endpackage

// File: rtl/of_decode.sv
// Opcode to control-word decoder; purely combinational.
// Upper nibble carries the ALU function, bit 3 is reg_write, [2:0] selects rd.
module of_decode
  import of_pkg::*;
#(
  parameter int unsigned CW = of_pkg::CTRL_W
) (
  input  logic [OPC_W-1:0] opcode,
  output logic [CW-1:0]    ctrl
);

  logic [7:0] ctrl8;

  // Map each opcode to its fixed control encoding; unknown opcodes act as NOP.
  always_comb begin
    ctrl8 = 8'h00;
    case (opcode)
      OP_ADD:   ctrl8 = 8'h19;
      OP_SUB:   ctrl8 = 8'h29;
      OP_AND:   ctrl8 = 8'h39;
      OP_CMP:   ctrl8 = 8'h40;
      OP_INC:   ctrl8 = 8'h58;
      OP_STORE: ctrl8 = 8'h60;
      default:  ctrl8 = 8'h00;
    endcase
    ctrl = CW'(ctrl8);
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: decode, register read with writeback bypass,
// scoreboard-based RAW stall and a registered valid/ready output bundle.
module operand_fetch_stage
  import of_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned CTRL_W = of_pkg::CTRL_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PC_W+4+3*$clog2(NREGS)-1:0] in_instr,
  input  logic                              wb_en,
  input  logic [$clog2(NREGS)-1:0]          wb_addr,
  input  logic [XLEN-1:0]                   wb_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CTRL_W-1:0]                 out_ctrl,
  output logic [PC_W-1:0]                   out_pc,
  output logic [XLEN-1:0]                   out_op_a,
  output logic [XLEN-1:0]                   out_op_b,
  output logic                              out_flag,
  output logic [2*$clog2(NREGS)-1:0]        out_imm,
  output logic [$clog2(NREGS)-1:0]          out_dest,
  output logic                              out_reg_write
);

  localparam int unsigned RAW    = $clog2(NREGS);
  localparam int unsigned O_OPC  = off_opcode(PC_W);
  localparam int unsigned O_RS1  = off_rs1(PC_W);
  localparam int unsigned O_RS2  = off_rs2(PC_W, RAW);
  localparam int unsigned O_RD   = off_rd(PC_W, RAW);

  logic [PC_W-1:0]   f_pc;
  logic [OPC_W-1:0]  f_opc;
  logic [RAW-1:0]    f_rs1, f_rs2, f_rd, dest;
  logic [CTRL_W-1:0] ctrl;
  logic [XLEN-1:0]   rd_a, rd_b;
  logic [XLEN-1:0]   rf [NREGS];
  logic [NREGS-1:0]  busy, busy_nxt;
  logic              wb_act, hazard, xfer, reg_write;

  assign f_pc  = in_instr[0 +: PC_W];
  assign f_opc = in_instr[O_OPC +: OPC_W];
  assign f_rs1 = in_instr[O_RS1 +: RAW];
  assign f_rs2 = in_instr[O_RS2 +: RAW];
  assign f_rd  = in_instr[O_RD +: RAW];

  of_decode #(.CW(CTRL_W)) u_decode (
    .opcode (f_opc),
    .ctrl   (ctrl)
  );

  // Operand read, hazard check and handshake; a writeback this cycle both
  // forwards its data and retires the matching scoreboard entry.
  always_comb begin
    wb_act    = wb_en && !rst;
    reg_write = ctrl[REG_WRITE_BIT];
    dest      = (|ctrl[USE_RD_MSB:USE_RD_LSB]) ? f_rd : f_rs1;
    rd_a      = (wb_act && wb_addr == f_rs1) ? wb_data : rf[f_rs1];
    rd_b      = (wb_act && wb_addr == f_rs2) ? wb_data : rf[f_rs2];
    hazard    = (busy[f_rs1] && !(wb_act && wb_addr == f_rs1)) ||
                (busy[f_rs2] && !(wb_act && wb_addr == f_rs2));
    in_ready  = !rst && !hazard && (!out_valid || out_ready);
    xfer      = in_valid && in_ready;
    busy_nxt  = busy;
    if (wb_act) busy_nxt[wb_addr] = 1'b0;
    if (xfer && reg_write) busy_nxt[dest] = 1'b1;
  end

  // Register file and scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      busy <= busy_nxt;
      if (wb_en) rf[wb_addr] <= wb_data;
    end
  end

  // Output bundle register: load on transfer, drop valid once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_ctrl      <= '0;
      out_pc        <= '0;
      out_op_a      <= '0;
      out_op_b      <= '0;
      out_flag      <= 1'b0;
      out_imm       <= '0;
      out_dest      <= '0;
      out_reg_write <= 1'b0;
    end else if (xfer) begin
      out_valid     <= 1'b1;
      out_ctrl      <= ctrl;
      out_pc        <= f_pc;
      out_op_a      <= rd_a;
      out_op_b      <= rd_b;
      out_flag      <= (rd_a == rd_b);
      out_imm       <= {f_rd, f_rs2};
      out_dest      <= dest;
      out_reg_write <= reg_write;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with hand-computed expectations.
module tb_operand_fetch_stage;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_CMP = 4'h4;
  localparam logic [3:0] OP_INC = 4'h5;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wb_en, out_valid, out_ready;
  logic        out_flag, out_reg_write;
  logic [23:0] in_instr;
  logic [3:0]  wb_addr, out_dest;
  logic [63:0] wb_data, out_op_a, out_op_b;
  logic [7:0]  out_ctrl, out_pc, out_imm;

  int n_cmp = 0;
  int n_mis = 0;

  operand_fetch_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_pc(out_pc), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_flag(out_flag), .out_imm(out_imm), .out_dest(out_dest),
    .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(logic [7:0] pc, logic [3:0] op,
                                     logic [3:0] r1, logic [3:0] r2, logic [3:0] rd);
    return {rd, r2, r1, op, pc};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(logic [3:0] a, logic [63:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = mk(8'h01, OP_ADD, 4'd0, 4'd0, 4'd1);
    wb(4'd9, 64'hDEAD);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    tick(); tick();
    rst = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_op_a", out_op_a, 64'd0);

    // Bypass of a same-cycle writeback.
    wb(4'd3, 64'h55);
    in_valid = 1'b1; in_instr = mk(8'h10, OP_CMP, 4'd3, 4'd0, 4'd1);
    #1 chk("bp_in_ready", 64'(in_ready), 64'd1);
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_op_a", out_op_a, 64'h55);
    chk("bp_op_b", out_op_b, 64'h0);
    chk("bp_flag", 64'(out_flag), 64'd0);
    chk("bp_pc", 64'(out_pc), 64'h10);
    chk("bp_ctrl", 64'(out_ctrl), 64'h40);
    chk("bp_dest", 64'(out_dest), 64'd3);
    chk("bp_rw", 64'(out_reg_write), 64'd0);

    // Writeback during reset was ignored; reg 3 kept 0x55.
    in_valid = 1'b1; in_instr = mk(8'h11, OP_CMP, 4'd9, 4'd3, 4'd0);
    tick();
    chk("rstwb_op_a", out_op_a, 64'h0);
    chk("rf_op_b", out_op_b, 64'h55);

    // Writer to r5, then dependent reader stalls until writeback of r5.
    in_instr = mk(8'h12, OP_ADD, 4'd0, 4'd0, 4'd5);
    tick();
    chk("wr_dest", 64'(out_dest), 64'd5);
    chk("wr_rw", 64'(out_reg_write), 64'd1);
    chk("wr_imm", 64'(out_imm), 64'h50);
    chk("wr_ctrl", 64'(out_ctrl), 64'h19);
    in_instr = mk(8'h13, OP_CMP, 4'd5, 4'd0, 4'd0);
    #1 chk("raw_stall", 64'(in_ready), 64'd0);
    tick();
    chk("raw_bubble", 64'(out_valid), 64'd0);
    chk("raw_stall2", 64'(in_ready), 64'd0);
    wb(4'd5, 64'h1234);
    #1 chk("raw_release", 64'(in_ready), 64'd1);
    tick();
    wb_en = 1'b0;
    chk("raw_valid", 64'(out_valid), 64'd1);
    chk("raw_op_a", out_op_a, 64'h1234);
    chk("raw_pc", 64'(out_pc), 64'h13);

    // Backpressure: bundle holds and input is blocked for 3 cycles.
    in_instr = mk(8'h20, OP_INC, 4'd3, 4'd3, 4'd0);
    tick();
    chk("inc_dest", 64'(out_dest), 64'd3);
    chk("inc_flag", 64'(out_flag), 64'd1);
    out_ready = 1'b0;
    in_instr = mk(8'h21, OP_CMP, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bpr_in_ready", 64'(in_ready), 64'd0);
      chk("bpr_pc", 64'(out_pc), 64'h20);
      chk("bpr_op_a", out_op_a, 64'h55);
      chk("bpr_valid", 64'(out_valid), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bpr_resume", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bpr_next_pc", 64'(out_pc), 64'h21);
    chk("bpr_next_valid", 64'(out_valid), 64'd1);
    wb(4'd3, 64'h56);
    tick();
    wb_en = 1'b0;

    // Same-cycle clear and set of r7: set must win.
    in_valid = 1'b1; in_instr = mk(8'h30, OP_ADD, 4'd0, 4'd0, 4'd7);
    tick();
    wb(4'd7, 64'h77);
    in_instr = mk(8'h31, OP_ADD, 4'd0, 4'd0, 4'd7);
    #1 chk("r7_reissue", 64'(in_ready), 64'd1);
    tick();
    wb_en = 1'b0;
    in_instr = mk(8'h32, OP_CMP, 4'd0, 4'd7, 4'd0);
    #1 chk("r7_still_busy", 64'(in_ready), 64'd0);
    tick();
    wb(4'd7, 64'h78);
    tick();
    wb_en = 1'b0;
    chk("r7_op_b", out_op_b, 64'h78);

    // Dest equal to its own source is not a hazard against itself.
    in_instr = mk(8'h33, OP_ADD, 4'd6, 4'd6, 4'd6);
    #1 chk("self_dep", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    wb(4'd6, 64'h66);
    tick();
    wb_en = 1'b0;

    // Equal operands set the flag; imm is {rd, rs2}.
    wb(4'd2, 64'hABCD);
    tick();
    wb_en = 1'b0;
    in_valid = 1'b1; in_instr = mk(8'h40, OP_CMP, 4'd2, 4'd2, 4'hA);
    tick();
    in_valid = 1'b0;
    chk("eq_flag", 64'(out_flag), 64'd1);
    chk("eq_op_a", out_op_a, 64'hABCD);
    chk("eq_imm", 64'(out_imm), 64'hA2);

    // Reset while stalled discards the bundle, scoreboard and register file.
    in_valid = 1'b1; in_instr = mk(8'h50, OP_ADD, 4'd0, 4'd0, 4'd4);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("mid_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_pc", 64'(out_pc), 64'd0);
    chk("mid_rst_dest", 64'(out_dest), 64'd0);
    in_valid = 1'b1; in_instr = mk(8'h51, OP_CMP, 4'd4, 4'd2, 4'd0);
    #1 chk("mid_busy_clr", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("mid_rf_a", out_op_a, 64'h0);
    chk("mid_rf_b", out_op_b, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
